pipeline_stage_register: RTL and testbench

Parametrised inter-stage pipeline register, the successor to the fixed-field Decode-to-Execute register. It carries an arbitrary control vector and data payload with a valid/ready handshake, so back-pressure from later stages can stall it, and a synchronous flush (CLR) turns its contents into a bubble. Any stage boundary of the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB) can use it. An optional skid slot makes in_ready a pure register output, which breaks the combinational ready path across stages.

---
 rtl/pipe_stage_pkg.sv | 47 ++++
 rtl/pipeline_stage_register_if.sv | 25 ++
 rtl/pipe_stage_slot.sv | 56 +++++
 rtl/pipeline_stage_register.sv | 90 +++++++++
 tb/tb_pipeline_stage_register.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared widths and ID/EX control field layout for the generic pipeline stage register.
// The skid option is selected with the PIPE_STAGE_SKID_EN macro; this package does not depend on it.
package pipe_stage_pkg;

  localparam int CTRL_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 96;

  localparam int IF_ID_CTRL_W  = 1;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 8;
  localparam int ID_EX_DATA_W  = 96;
  localparam int EX_MEM_CTRL_W = 4;
  localparam int EX_MEM_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 2;
  localparam int MEM_WB_DATA_W = 69;

  // ID/EX control vector bit positions
  localparam int ID_EX_REG_WRITE  = 0;
  localparam int ID_EX_MEM_TO_REG = 1;
  localparam int ID_EX_MEM_WRITE  = 2;
  localparam int ID_EX_ALU_CTRL_L = 3;
  localparam int ID_EX_ALU_CTRL_W = 3;
  localparam int ID_EX_ALU_SRC    = 6;
  localparam int ID_EX_REG_DST    = 7;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } id_ex_ctrl_t;

  function automatic logic [ID_EX_CTRL_W-1:0] pack_id_ex_ctrl(input id_ex_ctrl_t c);
    logic [ID_EX_CTRL_W-1:0] v;
    v = '0;
    v[ID_EX_REG_WRITE]  = c.reg_write;
    v[ID_EX_MEM_TO_REG] = c.mem_to_reg;
    v[ID_EX_MEM_WRITE]  = c.mem_write;
    v[ID_EX_ALU_CTRL_L +: ID_EX_ALU_CTRL_W] = c.alu_ctrl;
    v[ID_EX_ALU_SRC]    = c.alu_src;
    v[ID_EX_REG_DST]    = c.reg_dst;
    return v;
  endfunction

endpackage

// File: rtl/pipeline_stage_register_if.sv
// Valid/ready handshake bundle for one pipeline stage boundary (upstream in_*, downstream out_*).
// slave is the stage register's view; master is the surrounding pipeline's view.
interface pipeline_stage_register_if #(
  parameter int CTRL_WIDTH = 8,
  parameter int DATA_WIDTH = 96
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic [DATA_WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_slot.sv
// One valid+ctrl+data holding slot. Priority: clr > load > drain.
// clr and drain zero valid and ctrl but keep data, so a bubble carries no stale control.
module pipe_stage_slot #(
  parameter int CW = 8,
  parameter int DW = 96
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic          clr,
  input  logic [CW-1:0] ld_ctrl,
  input  logic [DW-1:0] ld_data,
  output logic          valid,
  output logic [CW-1:0] ctrl,
  output logic [DW-1:0] data
);

  logic          valid_d, valid_q;
  logic [CW-1:0] ctrl_d, ctrl_q;
  logic [DW-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = ld_ctrl;
      data_d  = ld_data;
    end else if (drain) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipeline_stage_register.sv
// Generic inter-stage register with valid/ready back-pressure and synchronous flush (CLR).
// Define PIPE_STAGE_SKID_EN to add a skid slot so in_ready comes from a flop instead of out_ready.
module pipeline_stage_register
  import pipe_stage_pkg::*;
#(
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  pipeline_stage_register_if.slave bus
);

  logic                  in_ready;
  logic                  accept;
  logic                  emit;
  logic                  load_m;
  logic                  drain_m;
  logic                  valid_m;
  logic [CTRL_WIDTH-1:0] ctrl_m;
  logic [DATA_WIDTH-1:0] data_m;
  logic [CTRL_WIDTH-1:0] ld_ctrl_m;
  logic [DATA_WIDTH-1:0] ld_data_m;

`ifdef PIPE_STAGE_SKID_EN
  logic                  valid_s;
  logic [CTRL_WIDTH-1:0] ctrl_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic                  load_s;
  logic                  drain_s;

  assign in_ready = CLR | ~valid_s;

  always_comb begin
    accept  = bus.in_valid & in_ready & ~CLR;
    emit    = valid_m & bus.out_ready;
    // skid refill and a fresh accept into main are mutually exclusive: valid_s holds in_ready low
    load_m  = (valid_s & emit) | (accept & (~valid_m | bus.out_ready));
    drain_m = emit & ~load_m;
    load_s  = accept & valid_m & ~bus.out_ready;
    drain_s = valid_s & emit;
    ld_ctrl_m = valid_s ? ctrl_s : bus.in_ctrl;
    ld_data_m = valid_s ? data_s : bus.in_data;
  end

  pipe_stage_slot #(.CW(CTRL_WIDTH), .DW(DATA_WIDTH)) u_slot_s (
    .clk     (CLK),
    .rst_n   (RST),
    .load    (load_s),
    .drain   (drain_s),
    .clr     (CLR),
    .ld_ctrl (bus.in_ctrl),
    .ld_data (bus.in_data),
    .valid   (valid_s),
    .ctrl    (ctrl_s),
    .data    (data_s)
  );
`else
  assign in_ready = CLR | ~valid_m | bus.out_ready;

  always_comb begin
    accept    = bus.in_valid & in_ready & ~CLR;
    emit      = valid_m & bus.out_ready;
    load_m    = accept;
    drain_m   = emit & ~accept;
    ld_ctrl_m = bus.in_ctrl;
    ld_data_m = bus.in_data;
  end
`endif

  pipe_stage_slot #(.CW(CTRL_WIDTH), .DW(DATA_WIDTH)) u_slot_m (
    .clk     (CLK),
    .rst_n   (RST),
    .load    (load_m),
    .drain   (drain_m),
    .clr     (CLR),
    .ld_ctrl (ld_ctrl_m),
    .ld_data (ld_data_m),
    .valid   (valid_m),
    .ctrl    (ctrl_m),
    .data    (data_m)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_m;
  assign bus.out_ctrl  = ctrl_m;
  assign bus.out_data  = data_m;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Self-checking bench: directed scenarios plus randomized valid/ready/flush traffic
// compared cycle by cycle against a FIFO-occupancy reference model.
module tb_pipeline_stage_register;

  localparam int CW = 8;
  localparam int DW = 96;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } entry_t;

  logic clk;
  logic rst;
  logic clr;
  int   n_tests;
  int   n_fail;

  entry_t        q[$];
  logic [DW-1:0] held_data;

  pipeline_stage_register_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) bus ();

  pipeline_stage_register #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .CLK (clk),
    .RST (rst),
    .CLR (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_ready(input logic ordy, input logic c);
    if (c) return 1'b1;
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || ordy;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: drive inputs after negedge, check outputs, then advance the model at posedge.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl, output logic acc);
    logic exp_rdy;
    logic emit;
    entry_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clr           = fl;
    #1;
    check("out_valid", bus.out_valid, q.size() > 0);
    check("out_ctrl", bus.out_ctrl, q.size() > 0 ? q[0].c : '0);
    check("out_data", bus.out_data, q.size() > 0 ? q[0].d : held_data);
    check("in_ready", bus.in_ready, model_ready(ordy, fl));
    bus.out_ready = ~ordy;
    #1;
    check("in_ready_flip", bus.in_ready, model_ready(~ordy, fl));
    bus.out_ready = ordy;
    #1;
    exp_rdy = model_ready(ordy, fl);
    acc  = v & exp_rdy & ~fl;
    emit = (q.size() > 0) & ordy;
    @(posedge clk);
    if (q.size() > 0) held_data = q[0].d;
    if (fl) begin
      q.delete();
    end else begin
      if (emit) void'(q.pop_front());
      if (acc) begin
        e.c = c;
        e.d = d;
        q.push_back(e);
      end
    end
    if (q.size() > 0) held_data = q[0].d;
  endtask

  // Present one entry until accepted, bounded.
  task automatic send(input logic [CW-1:0] c, input logic ordy);
    logic acc;
    logic [DW-1:0] d;
    d   = rand_data();
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) step(1'b1, c, d, ordy, 1'b0, acc);
    check("send_accept", acc, 1'b1);
  endtask

  task automatic idle(input logic ordy, input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, ordy, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    logic [DW-1:0] d;
    n_tests = 0;
    n_fail  = 0;
    held_data = '0;
    rst = 1'b0;
    clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_ctrl", bus.out_ctrl, '0);
    check("rst_out_data", bus.out_data, '0);
    #1 rst = 1'b1;

    // back-to-back stream, 0x01..0x04
    for (int i = 1; i <= 4; i++) begin
      d = rand_data();
      step(1'b1, CW'(i), d, 1'b1, 1'b0, acc);
      check("stream_accept", acc, 1'b1);
    end
    idle(1'b1, 2);

    // stall: A then B with downstream blocked, then release
    send(8'h11, 1'b0);
    d = rand_data();
    acc = 1'b0;
    for (int t = 0; t < 2 && !acc; t++) step(1'b1, 8'h22, d, 1'b0, 1'b0, acc);
    for (int t = 0; t < 4 && !acc; t++) step(1'b1, 8'h22, d, 1'b1, 1'b0, acc);
    check("stall_b_accept", acc, 1'b1);
    idle(1'b1, 3);

    // flush with entries resident and a competing input
    send(8'h66, 1'b0);
    if (CAP == 2) send(8'h77, 1'b0);
    step(1'b1, 8'h33, rand_data(), 1'b0, 1'b1, acc);
    idle(1'b1, 2);

    // flush together with out_ready
    send(8'h68, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, acc);
    idle(1'b1, 1);

    // simultaneous accept and emit
    send(8'h44, 1'b0);
    step(1'b1, 8'h55, rand_data(), 1'b1, 1'b0, acc);
    check("simul_accept", acc, 1'b1);
    idle(1'b1, 2);

    // async reset mid-stall
    send(8'h91, 1'b0);
    if (CAP == 2) send(8'h92, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_data", bus.out_data, '0);
    check("arst_out_ctrl", bus.out_ctrl, '0);
    q.delete();
    held_data = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    idle(1'b1, 2);

    // randomized traffic
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, CW'($urandom()), rand_data(),
           $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, acc);
    end
    idle(1'b1, 3);
    check("final_empty", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
